// File: rtl/bnn_layer_scheduler.sv
// Sequences OC output channels through one shared binary conv/pool core: fetch a weight
// word, load it, let the core settle, write the pooled result. Optional macro: BNN_SCHED_PERF_EN.
module bnn_layer_scheduler #(
  parameter int IC        = 4,
  parameter int OC        = 8,
  parameter int POOL_BITS = 196,
  parameter int CORE_LAT  = 1,
  localparam int OCW      = $clog2(OC)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 wmem_rd_en,
  output logic [OCW-1:0]       wmem_addr,
  input  logic [IC*9-1:0]      wmem_rdata,
  output logic [IC*9-1:0]      core_weight,
  input  logic [POOL_BITS-1:0] core_result,
  output logic [OCW-1:0]       oc_idx,
  output logic                 res_we,
  output logic [OCW-1:0]       res_addr,
  output logic [POOL_BITS-1:0] res_data
`ifdef BNN_SCHED_PERF_EN
  ,
  output logic [15:0]          perf_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LOAD, S_SETTLE, S_WRITE, S_DONE
  } state_t;

  localparam logic [3:0]     SETTLE_INIT = (CORE_LAT > 0) ? 4'(CORE_LAT - 1) : 4'd0;
  localparam logic [OCW-1:0] OC_LAST     = OCW'(OC - 1);

  state_t     state, state_nxt;
  logic [3:0] settle_cnt;
  logic       run_accept;
  logic       last_ch;

  assign run_accept = (state == S_IDLE) && start && !abort;
  assign last_ch    = (oc_idx == OC_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state != S_IDLE && abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (run_accept) state_nxt = S_FETCH;
        S_FETCH:  state_nxt = S_LOAD;
        S_LOAD:   state_nxt = (CORE_LAT > 0) ? S_SETTLE : S_WRITE;
        S_SETTLE: if (settle_cnt == 4'd0) state_nxt = S_WRITE;
        S_WRITE:  state_nxt = last_ch ? S_DONE : S_FETCH;
        S_DONE:   state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Channel index, weight register and settle down-counter; an aborted LOAD keeps the old weight.
  always_ff @(posedge clk) begin
    if (rst) begin
      oc_idx      <= '0;
      core_weight <= '0;
      settle_cnt  <= '0;
    end else begin
      if (run_accept)
        oc_idx <= '0;
      else if (state == S_WRITE && !abort && !last_ch)
        oc_idx <= oc_idx + 1'b1;

      if (state == S_LOAD && !abort) begin
        core_weight <= wmem_rdata;
        settle_cnt  <= SETTLE_INIT;
      end else if (state == S_SETTLE && settle_cnt != 4'd0) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
    end
  end

  // Strobes are suppressed in a cycle where abort or rst is already high.
  always_comb begin
    busy       = (state != S_IDLE);
    wmem_rd_en = 1'b0;
    wmem_addr  = '0;
    res_we     = 1'b0;
    res_addr   = '0;
    res_data   = '0;
    done       = 1'b0;
    case (state)
      S_FETCH: if (!abort && !rst) begin
        wmem_rd_en = 1'b1;
        wmem_addr  = oc_idx;
      end
      S_WRITE: if (!abort && !rst) begin
        res_we   = 1'b1;
        res_addr = oc_idx;
        res_data = core_result;
      end
      S_DONE:  done = !abort && !rst;
      default: ;
    endcase
  end

`ifdef BNN_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)
      perf_cycles <= '0;
    else if (run_accept)
      perf_cycles <= '0;
    else if (busy && perf_cycles != 16'hFFFF)
      perf_cycles <= perf_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Directed bench for bnn_layer_scheduler: default instance plus an OC=4, CORE_LAT=0 instance,
// with a weight-memory model and a core that echoes core_weight.
module tb_bnn_layer_scheduler;

  logic clk = 1'b0;
  logic rst, start, abort, start0, abort0;
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;

  // default instance
  logic         busy, done, wmem_rd_en, res_we;
  logic [2:0]   wmem_addr, oc_idx, res_addr;
  logic [35:0]  wmem_rdata, core_weight;
  logic [195:0] core_result, res_data;
  // OC=4, CORE_LAT=0 instance
  logic         busy0, done0, wmem0_rd_en, res0_we;
  logic [1:0]   wmem0_addr, oc0_idx, res0_addr;
  logic [35:0]  wmem0_rdata, core0_weight;
  logic [195:0] core0_result, res0_data;
`ifdef BNN_SCHED_PERF_EN
  logic [15:0]  perf_cycles, perf0_cycles;
`endif

  logic [35:0] wtab [8] = '{36'h00, 36'h11, 36'h22, 36'h33, 36'h44, 36'h55, 36'h66, 36'h77};
  logic [39:0] exp_q[$];
  logic [39:0] exp0_q[$];
  logic [39:0] e_mon, e0_mon;
  int we_count = 0, done_count = 0, done_cyc = 0;
  int we0_count = 0, done0_count = 0, done0_cyc = 0, last_we0_cyc = -1;

  bnn_layer_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .wmem_rdata(wmem_rdata),
    .core_weight(core_weight), .core_result(core_result), .oc_idx(oc_idx),
    .res_we(res_we), .res_addr(res_addr), .res_data(res_data)
`ifdef BNN_SCHED_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  bnn_layer_scheduler #(.OC(4), .CORE_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .busy(busy0), .done(done0),
    .wmem_rd_en(wmem0_rd_en), .wmem_addr(wmem0_addr), .wmem_rdata(wmem0_rdata),
    .core_weight(core0_weight), .core_result(core0_result), .oc_idx(oc0_idx),
    .res_we(res0_we), .res_addr(res0_addr), .res_data(res0_data)
`ifdef BNN_SCHED_PERF_EN
    , .perf_cycles(perf0_cycles)
`endif
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // memory and core models
  always @(posedge clk) begin
    if (wmem_rd_en)  wmem_rdata  <= wtab[wmem_addr];
    if (wmem0_rd_en) wmem0_rdata <= wtab[3'(wmem0_addr)];
  end
  assign core_result  = 196'(core_weight);
  assign core0_result = 196'(core0_weight);

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_done(input bit which, input int prev, input int budget);
    int n = 0;
    while (((which ? done0_count : done_count) == prev) && n < budget) begin
      tick();
      n++;
    end
    if ((which ? done0_count : done_count) == prev)
      check("done_timeout", 256'(which ? done0_count : done_count), 256'(prev + 1));
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (wmem_rd_en || res_we || done)
      check("excl", 256'(32'(wmem_rd_en) + 32'(res_we) + 32'(done)), 256'd1);
    if (res_we) begin
      we_count++;
      if (exp_q.size() == 0) begin
        check("unexp_we", 256'(res_we), 256'd0);
      end else begin
        e_mon = exp_q.pop_front();
        check("we_addr", 256'(res_addr), 256'(e_mon[39:36]));
        check("we_data", 256'(res_data), 256'(e_mon[35:0]));
      end
    end
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  always @(negedge clk) begin
    if (res0_we) begin
      we0_count++;
      if (last_we0_cyc >= 0) check("lat0_spacing", 256'(cyc - last_we0_cyc), 256'd3);
      last_we0_cyc = cyc;
      if (exp0_q.size() == 0) begin
        check("unexp_we0", 256'(res0_we), 256'd0);
      end else begin
        e0_mon = exp0_q.pop_front();
        check("we0_addr", 256'(res0_addr), 256'(e0_mon[39:36]));
        check("we0_data", 256'(res0_data), 256'(e0_mon[35:0]));
      end
    end
    if (done0) begin
      done0_count++;
      done0_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, d1, bw, bd;
    rst = 1'b1; start = 1'b0; abort = 1'b0; start0 = 1'b0; abort0 = 1'b0;
    tick(); tick();
    check("rst_busy", 256'(busy), 256'd0);
    check("rst_done", 256'(done), 256'd0);
    check("rst_rd_en", 256'(wmem_rd_en), 256'd0);
    check("rst_we", 256'(res_we), 256'd0);
    check("rst_oc_idx", 256'(oc_idx), 256'd0);
    check("rst_weight", 256'(core_weight), 256'd0);
    check("rst_res_addr", 256'(res_addr), 256'd0);
    check("rst_res_data", 256'(res_data), 256'd0);
    rst = 1'b0;
    tick();

    // full default run, echoing weights
    for (int k = 0; k < 8; k++) exp_q.push_back({4'(k), wtab[k]});
    bw = we_count; bd = done_count;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    wait_done(1'b0, bd, 100);
    check("t1_latency", 256'(done_cyc - s), 256'd33);
    tick();
    check("t1_idle", 256'(busy), 256'd0);
    check("t1_writes", 256'(we_count - bw), 256'd8);
    check("t1_dones", 256'(done_count - bd), 256'd1);
`ifdef BNN_SCHED_PERF_EN
    check("t1_perf", 256'(perf_cycles), 256'd33);
`endif

    // OC=4, CORE_LAT=0 instance
    for (int k = 0; k < 4; k++) exp0_q.push_back({4'(k), wtab[k]});
    start0 = 1'b1; s = cyc; tick(); start0 = 1'b0;
    wait_done(1'b1, 0, 60);
    check("lat0_latency", 256'(done0_cyc - s), 256'd13);
    check("lat0_writes", 256'(we0_count), 256'd4);
    tick();

    // abort during SETTLE of channel 3
    for (int k = 0; k < 3; k++) exp_q.push_back({4'(k), wtab[k]});
    bw = we_count; bd = done_count;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    repeat (13) tick();
    @(posedge clk); #1; abort = 1'b1;
    check("t2_busy_pre", 256'(busy), 256'd1);
    @(posedge clk); #1; abort = 1'b0;
    check("t2_idle", 256'(busy), 256'd0);
    check("t2_weight_held", 256'(core_weight), 256'h33);
    repeat (4) tick();
    check("t2_writes", 256'(we_count - bw), 256'd3);
    check("t2_no_done", 256'(done_count - bd), 256'd0);

    // abort in WRITE of channel 0 suppresses the write
    bw = we_count;
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("t3_idle", 256'(busy), 256'd0);
    repeat (3) tick();
    check("t3_writes", 256'(we_count - bw), 256'd0);

    // reset in WRITE of channel 5
    for (int k = 0; k < 5; k++) exp_q.push_back({4'(k), wtab[k]});
    bw = we_count; bd = done_count;
    start = 1'b1; tick(); start = 1'b0;
    repeat (22) tick();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    check("t4_busy", 256'(busy), 256'd0);
    check("t4_done", 256'(done), 256'd0);
    check("t4_rd_en", 256'(wmem_rd_en), 256'd0);
    check("t4_we", 256'(res_we), 256'd0);
    check("t4_oc_idx", 256'(oc_idx), 256'd0);
    check("t4_weight", 256'(core_weight), 256'd0);
    check("t4_res_addr", 256'(res_addr), 256'd0);
    check("t4_res_data", 256'(res_data), 256'd0);
    rst = 1'b0;
    repeat (3) tick();
    check("t4_writes", 256'(we_count - bw), 256'd5);
    check("t4_no_done", 256'(done_count - bd), 256'd0);

    // start+abort together in IDLE, then start re-pulsed while busy
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("t5_abort_wins", 256'(busy), 256'd0);
    for (int k = 0; k < 8; k++) exp_q.push_back({4'(k), wtab[k]});
    bw = we_count; bd = done_count;
    start = 1'b1; s = cyc; tick(); start = 1'b0;
    repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_done(1'b0, bd, 100);
    check("t5_latency", 256'(done_cyc - s), 256'd33);
    repeat (3) tick();
    check("t5_writes", 256'(we_count - bw), 256'd8);
    check("t5_dones", 256'(done_count - bd), 256'd1);
    check("t5_idle", 256'(busy), 256'd0);

    // start held high: back-to-back runs
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 8; k++) exp_q.push_back({4'(k), wtab[k]});
    bw = we_count; bd = done_count;
    start = 1'b1; s = cyc;
    wait_done(1'b0, bd, 100);
    d1 = done_cyc;
    check("t6_latency1", 256'(d1 - s), 256'd33);
    tick();
    check("t6_gap_idle", 256'(busy), 256'd0);
    tick();
    check("t6_rerun", 256'(busy), 256'd1);
    wait_done(1'b0, bd + 1, 100);
    start = 1'b0;
    check("t6_spacing", 256'(done_cyc - d1), 256'd34);
    repeat (3) tick();
    check("t6_dones", 256'(done_count - bd), 256'd2);
    check("t6_writes", 256'(we_count - bw), 256'd16);
    check("t6_idle", 256'(busy), 256'd0);

    check("exp_q_drained", 256'(exp_q.size()), 256'd0);
    check("exp0_q_drained", 256'(exp0_q.size()), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
